// File: rtl/costas_acq_seq.sv
// Acquisition sequencer for the Costas carrier loop: zig-zag sweeps the loop's initial
// FTW around a centre word until a windowed lock metric passes, then watches for loss.
module costas_acq_seq #(
    parameter int REWORK_CYC = 4,
    parameter int SETTLE_CYC = 4096,
    parameter int WIN_LEN    = 1024,
    parameter int LOCK_THR   = 900,
    parameter int LOSS_THR   = 512,
    parameter int MAX_OFS    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [31:0] i_ftw_center,
    input  logic [31:0] i_ftw_step,
    input  logic        i_lock_valid,
    input  logic        i_lock_ok,
    output logic [31:0] o_ftw_ini,
    output logic        o_rework_h,
    output logic        o_locked,
    output logic        o_fail,
    output logic        o_busy,
    output logic [4:0]  o_step_idx,
    output logic [15:0] o_hits
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_MEASURE, S_DECIDE, S_LOCKED, S_FAIL
    } state_t;

    localparam logic [15:0] REWORK_LAST = 16'(REWORK_CYC - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
    localparam logic [15:0] WIN_L       = 16'(WIN_LEN);
    localparam logic [15:0] LOCK_T      = 16'(LOCK_THR);
    localparam logic [15:0] LOSS_T      = 16'(LOSS_THR);
    localparam logic [4:0]  K_LAST      = 5'(2 * MAX_OFS);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] samp_q, samp_d;
    logic [15:0] hits_q, hits_d;
    logic [4:0]  k_q, k_d;
    logic [31:0] c_q, c_d;
    logic [31:0] s_q, s_d;
    logic [31:0] pos_q, pos_d;
    logic [31:0] neg_q, neg_d;
    logic [31:0] ftw_q, ftw_d;
    logic [15:0] hits_out_q, hits_out_d;
    logic        rework_q, rework_d;
    logic        locked_q, locked_d;
    logic        fail_q, fail_d;
    logic        busy_q, busy_d;

    logic [15:0] samp_inc;
    logic [15:0] hits_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            samp_q     <= '0;
            hits_q     <= '0;
            k_q        <= '0;
            ftw_q      <= '0;
            hits_out_q <= '0;
            rework_q   <= 1'b1;
            locked_q   <= 1'b0;
            fail_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            samp_q     <= samp_d;
            hits_q     <= hits_d;
            k_q        <= k_d;
            ftw_q      <= ftw_d;
            hits_out_q <= hits_out_d;
            rework_q   <= rework_d;
            locked_q   <= locked_d;
            fail_q     <= fail_d;
            busy_q     <= busy_d;
        end
    end

    // Sweep words live only in the datapath; they are always reloaded on start.
    always_ff @(posedge clk) begin
        c_q   <= c_d;
        s_q   <= s_d;
        pos_q <= pos_d;
        neg_q <= neg_d;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        samp_d     = samp_q;
        hits_d     = hits_q;
        k_d        = k_q;
        c_d        = c_q;
        s_d        = s_q;
        pos_d      = pos_q;
        neg_d      = neg_q;
        ftw_d      = ftw_q;
        hits_out_d = hits_out_q;
        samp_inc   = samp_q + 16'd1;
        hits_inc   = hits_q + {15'd0, i_lock_ok};

        if (i_abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            samp_d  = '0;
            hits_d  = '0;
            k_d     = '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_FAIL: begin
                    if (i_start) begin
                        state_d = S_LOAD;
                        c_d     = i_ftw_center;
                        s_d     = i_ftw_step;
                        pos_d   = i_ftw_center;
                        neg_d   = i_ftw_center;
                        ftw_d   = i_ftw_center;
                        k_d     = '0;
                        cnt_d   = '0;
                    end
                end
                S_LOAD: begin
                    if (cnt_q == REWORK_LAST) begin
                        state_d = S_SETTLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = S_MEASURE;
                        cnt_d   = '0;
                        samp_d  = '0;
                        hits_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                S_MEASURE: begin
                    if (i_lock_valid) begin
                        samp_d = samp_inc;
                        hits_d = hits_inc;
                        if (samp_inc == WIN_L) begin
                            state_d = S_DECIDE;
                        end
                    end
                end
                S_DECIDE: begin
                    hits_out_d = hits_q;
                    if (hits_q >= LOCK_T) begin
                        state_d = S_LOCKED;
                        samp_d  = '0;
                        hits_d  = '0;
                    end else if (k_q < K_LAST) begin
                        // Odd k steps the positive arm out, even k the negative arm.
                        state_d = S_LOAD;
                        k_d     = k_q + 5'd1;
                        cnt_d   = '0;
                        if (!k_q[0]) begin
                            pos_d = pos_q + s_q;
                            ftw_d = pos_q + s_q;
                        end else begin
                            neg_d = neg_q - s_q;
                            ftw_d = neg_q - s_q;
                        end
                    end else begin
                        state_d = S_FAIL;
                    end
                end
                S_LOCKED: begin
                    if (i_lock_valid) begin
                        if (samp_inc == WIN_L) begin
                            hits_out_d = hits_inc;
                            samp_d     = '0;
                            hits_d     = '0;
                            if (hits_inc < LOSS_T) begin
                                state_d = S_LOAD;
                                k_d     = '0;
                                cnt_d   = '0;
                                pos_d   = c_q;
                                neg_d   = c_q;
                                ftw_d   = c_q;
                            end
                        end else begin
                            samp_d = samp_inc;
                            hits_d = hits_inc;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        rework_d = (state_d == S_IDLE) || (state_d == S_LOAD) || (state_d == S_FAIL);
        locked_d = (state_d == S_LOCKED);
        fail_d   = (state_d == S_FAIL);
        busy_d   = (state_d == S_LOAD) || (state_d == S_SETTLE) ||
                   (state_d == S_MEASURE) || (state_d == S_DECIDE);
    end

    assign o_ftw_ini  = ftw_q;
    assign o_rework_h = rework_q;
    assign o_locked   = locked_q;
    assign o_fail     = fail_q;
    assign o_busy     = busy_q;
    assign o_step_idx = k_q;
    assign o_hits     = hits_out_q;

endmodule
